// File: rtl/bcd_display_scanner_if.sv
// Load handshake plus multiplexed segment/anode bus for bcd_display_scanner.
interface bcd_display_scanner_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    load_valid;
   logic                    load_ready;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   dig_en;
   logic                    frame_tick;

   modport master (
      output load_valid, digits, dp_mask,
      input  load_ready, seg, dp, dig_en, frame_tick
   );

   modport slave (
      input  load_valid, digits, dp_mask,
      output load_ready, seg, dp, dig_en, frame_tick
   );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexes a double-buffered packed BCD value onto one active-low 7-segment bus.
// Optional LEADING_ZERO_BLANK_EN darkens zero digits above the most significant non-zero digit.
module bcd_display_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input logic                 clk,
   input logic                 rst,
   bcd_display_scanner_if.slave bus
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]                refresh_cnt;
   logic [IW-1:0]                idx;
   logic [NUM_DIGITS-1:0][3:0]   disp_dig;
   logic [NUM_DIGITS-1:0]        disp_dp;
   logic [NUM_DIGITS-1:0][3:0]   pend_dig;
   logic [NUM_DIGITS-1:0]        pend_dp;
   logic                         pend_full;
   logic                         load_ready_q;
   logic                         slot_end;
   logic                         frame_wrap;
   logic                         accept;
   logic [NUM_DIGITS-1:0]        blank_mask;
   logic [6:0]                   seg_q, seg_nxt;
   logic                         dp_q, dp_nxt;
   logic [NUM_DIGITS-1:0]        dig_en_q, dig_en_nxt;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b0000001;
         4'd1:    decode = 7'b1001111;
         4'd2:    decode = 7'b0010010;
         4'd3:    decode = 7'b0000110;
         4'd4:    decode = 7'b1001100;
         4'd5:    decode = 7'b0100100;
         4'd6:    decode = 7'b0100000;
         4'd7:    decode = 7'b0001111;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0000100;
         default: decode = 7'b1111111;
      endcase
   endfunction

   assign slot_end   = (refresh_cnt == CNT_LAST);
   assign frame_wrap = slot_end && (idx == IDX_LAST);
   assign accept     = bus.load_valid && load_ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         refresh_cnt <= '0;
         idx         <= '0;
      end else if (slot_end) begin
         refresh_cnt <= '0;
         idx         <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   // Pending only drains into the display at the frame wrap, so a frame never mixes two values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_dig     <= '0;
         pend_dp      <= '0;
         pend_full    <= 1'b0;
         disp_dig     <= '0;
         disp_dp      <= '0;
         load_ready_q <= 1'b0;
      end else begin
         if (accept) begin
            pend_dig  <= bus.digits;
            pend_dp   <= bus.dp_mask;
            pend_full <= 1'b1;
         end else if (frame_wrap && pend_full) begin
            disp_dig  <= pend_dig;
            disp_dp   <= pend_dp;
            pend_full <= 1'b0;
         end
         load_ready_q <= !(accept || (pend_full && !frame_wrap));
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic lz_seen;
   always_comb begin
      blank_mask = '0;
      lz_seen    = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (disp_dig[i] != 4'd0) lz_seen = 1'b1;
         blank_mask[i] = !lz_seen;
      end
   end
`else
   assign blank_mask = '0;
`endif

   always_comb begin
      seg_nxt    = 7'h7F;
      dp_nxt     = 1'b1;
      dig_en_nxt = '1;
      if (int'(refresh_cnt) >= BLANK_CYCLES) begin
         dig_en_nxt = ~(NUM_DIGITS'(1) << idx);
         seg_nxt    = blank_mask[idx] ? 7'h7F : decode(disp_dig[idx]);
         dp_nxt     = ~disp_dp[idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q    <= 7'h7F;
         dp_q     <= 1'b1;
         dig_en_q <= '1;
      end else begin
         seg_q    <= seg_nxt;
         dp_q     <= dp_nxt;
         dig_en_q <= dig_en_nxt;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.dig_en     = dig_en_q;
   assign bus.frame_tick = frame_wrap;
   assign bus.load_ready = load_ready_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_bcd_display_scanner;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n     = 0;

   bcd_display_scanner_if #(.NUM_DIGITS(4)) bus ();

   bcd_display_scanner #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (8),
      .BLANK_CYCLES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ_SEG = 7'h7F;
`else
   localparam logic [6:0] LZ_SEG = 7'h01;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      n++;
      @(negedge clk);
      chk("dig_en_onehot", 32'($countones(~bus.dig_en) <= 1), 32'd1);
   endtask

   task automatic run_to(input int target);
      while (n < target) tick();
   endtask

   task automatic chk_slot(input string tag, input logic [6:0] s, input logic d, input logic [3:0] en);
      chk({tag, "_seg"}, 32'(bus.seg), 32'(s));
      chk({tag, "_dp"}, 32'(bus.dp), 32'(d));
      chk({tag, "_en"}, 32'(bus.dig_en), 32'(en));
   endtask

   initial begin
      rst            = 1'b1;
      bus.load_valid = 1'b0;
      bus.digits     = '0;
      bus.dp_mask    = '0;
      repeat (3) @(negedge clk);
      chk_slot("rst", 7'h7F, 1'b1, 4'hF);
      chk("rst_ready", 32'(bus.load_ready), 32'd0);
      chk("rst_tick", 32'(bus.frame_tick), 32'd0);

      rst = 1'b0;
      n   = 0;
      tick();
      chk_slot("rel1", 7'h7F, 1'b1, 4'hF);
      chk("rel1_ready", 32'(bus.load_ready), 32'd1);
      tick();
      chk_slot("rel2", 7'h7F, 1'b1, 4'hF);
      tick();
      chk_slot("rel3_d0", 7'h01, 1'b1, 4'hE);

      // value 1234 offered mid-frame
      bus.load_valid = 1'b1;
      bus.digits     = 16'h1234;
      bus.dp_mask    = 4'b0000;
      tick();
      bus.load_valid = 1'b0;
      chk("acc1234_ready", 32'(bus.load_ready), 32'd0);
      run_to(11);
      chk_slot("old_d1", 7'h01, 1'b1, 4'hD);
      run_to(31);
      chk("tick31", 32'(bus.frame_tick), 32'd1);
      chk("tick31_ready", 32'(bus.load_ready), 32'd0);
      tick();
      chk("tick32", 32'(bus.frame_tick), 32'd0);
      chk("drain_ready", 32'(bus.load_ready), 32'd1);
      tick();
      chk_slot("blank33", 7'h7F, 1'b1, 4'hF);
      run_to(35); chk_slot("v1234_d0", 7'h4C, 1'b1, 4'hE);
      run_to(43); chk_slot("v1234_d1", 7'h06, 1'b1, 4'hD);
      run_to(51); chk_slot("v1234_d2", 7'h12, 1'b1, 4'hB);
      run_to(59); chk_slot("v1234_d3", 7'h4F, 1'b1, 4'h7);

      // 00A7 with decimal point on digit 1
      run_to(60);
      bus.load_valid = 1'b1;
      bus.digits     = 16'h00A7;
      bus.dp_mask    = 4'b0010;
      tick();
      bus.load_valid = 1'b0;
      chk("accA7_ready", 32'(bus.load_ready), 32'd0);
      run_to(67); chk_slot("vA7_d0", 7'h0F, 1'b1, 4'hE);
      run_to(75); chk_slot("vA7_d1", 7'h7F, 1'b0, 4'hD);
      run_to(83); chk_slot("vA7_d2", LZ_SEG, 1'b1, 4'hB);

      // offer exactly on the frame_tick cycle
      run_to(95);
      chk("tick95", 32'(bus.frame_tick), 32'd1);
      bus.load_valid = 1'b1;
      bus.digits     = 16'h5678;
      bus.dp_mask    = 4'b0000;
      tick();
      bus.load_valid = 1'b0;
      chk("acc5678_ready", 32'(bus.load_ready), 32'd0);
      run_to(99);  chk_slot("held_d0", 7'h0F, 1'b1, 4'hE);
      run_to(127); chk("tick127", 32'(bus.frame_tick), 32'd1);
      run_to(131); chk_slot("v5678_d0", 7'h00, 1'b1, 4'hE);
      run_to(139); chk_slot("v5678_d1", 7'h0F, 1'b1, 4'hD);

      // reset mid-slot with pending full
      bus.load_valid = 1'b1;
      bus.digits     = 16'h9999;
      tick();
      bus.load_valid = 1'b0;
      chk("acc9999_ready", 32'(bus.load_ready), 32'd0);
      tick();
      rst = 1'b1;
      #1;
      chk_slot("async_rst", 7'h7F, 1'b1, 4'hF);
      chk("async_rst_ready", 32'(bus.load_ready), 32'd0);
      chk("async_rst_tick", 32'(bus.frame_tick), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n   = 0;
      run_to(3);
      chk_slot("rst2_d0", 7'h01, 1'b1, 4'hE);
      chk("rst2_ready", 32'(bus.load_ready), 32'd1);
      run_to(35);
      chk_slot("no_stale_d0", 7'h01, 1'b1, 4'hE);

      // 0005 and 0000 exercise leading-zero handling
      bus.load_valid = 1'b1;
      bus.digits     = 16'h0005;
      tick();
      bus.load_valid = 1'b0;
      run_to(67); chk_slot("v5_d0", 7'h24, 1'b1, 4'hE);
      run_to(75); chk_slot("v5_d1", LZ_SEG, 1'b1, 4'hD);
      run_to(91); chk_slot("v5_d3", LZ_SEG, 1'b1, 4'h7);
      bus.load_valid = 1'b1;
      bus.digits     = 16'h0000;
      tick();
      bus.load_valid = 1'b0;
      run_to(99);  chk_slot("v0_d0", 7'h01, 1'b1, 4'hE);
      run_to(107); chk_slot("v0_d1", LZ_SEG, 1'b1, 4'hD);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
